svc_rv_dmem_router: RTL and testbench

Data-side interconnect between an `svc_rv` core (MEM_TYPE_BRAM timing) and its memories. It generalises the fixed BRAM/single-I/O split to NUM_IO memory-mapped I/O channels. Each channel uses a valid/ready request and a variable-latency response. The router drives `dmem_stall` for I/O wait states, times out hung peripherals, and flags decode errors. It sits inside the BRAM SoC, between `cpu` and `dmem`/peripherals.

---
 rtl/svc_rv_dmem_router_pkg.sv | 29 ++
 rtl/svc_rv_dmem_decode.sv | 36 +++
 rtl/svc_rv_dmem_router.sv | 258 +++++++++++++++++++++++++
 tb/tb_svc_rv_dmem_router.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_dmem_router_pkg.sv
// Shared types and constants for the svc_rv data-side router.
//   state_e     : router FSM states
//   io_req_t    : registered I/O request payload
//   ERR_RDATA   : read data returned on decode error or timeout
//   IO_SEL_BIT  : address bit that selects I/O space over BRAM
package svc_rv_dmem_router_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned IO_SEL_BIT = 31;

    localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } io_req_t;

endpackage

// File: rtl/svc_rv_dmem_decode.sv
// Combinational base/mask priority decoder for I/O space.
//   addr   : access address
//   hit_c  : raw per-channel match vector (only when IO_SEL_BIT is set)
//   ch_c   : lowest matching channel index
//   miss_c : I/O-space address that matches no channel
module svc_rv_dmem_decode
    import svc_rv_dmem_router_pkg::*;
#(
    parameter int unsigned          NUM_IO  = 2,
    parameter logic [32*NUM_IO-1:0] IO_BASE = {NUM_IO{32'h8000_0000}},
    parameter logic [32*NUM_IO-1:0] IO_MASK = {NUM_IO{32'hFFFF_F000}},
    localparam int unsigned         CH_W    = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NUM_IO-1:0] hit_c,
    output logic [CH_W-1:0]   ch_c,
    output logic              miss_c
);

    always_comb begin
        hit_c = '0;
        ch_c  = '0;
        for (int i = 0; i < int'(NUM_IO); i++) begin
            hit_c[i] = addr[IO_SEL_BIT]
                && ((addr & IO_MASK[32*i +: 32]) == IO_BASE[32*i +: 32]);
        end
        // Walk downward so the lowest matching index is the final winner.
        for (int i = int'(NUM_IO) - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                ch_c = CH_W'(i);
            end
        end
        miss_c = addr[IO_SEL_BIT] && (hit_c == '0);
    end

endmodule

// File: rtl/svc_rv_dmem_router.sv
// Data-side router between an svc_rv core (BRAM timing) and BRAM plus
// NUM_IO memory-mapped I/O channels.
//   clk, rst                 : clock, synchronous active-high reset
//   dmem_r*/dmem_w*          : core read/write ports, dmem_stall holds core
//   bram_ren/bram_wen        : BRAM strobes (address/data pass through)
//   io_req_*                 : per-channel valid/ready, shared payload
//   io_rsp_*                 : per-channel read response
//   bus_err/err_addr         : error pulse and last error address
module svc_rv_dmem_router
    import svc_rv_dmem_router_pkg::*;
#(
    parameter int unsigned          NUM_IO  = 2,
    parameter logic [32*NUM_IO-1:0] IO_BASE = {NUM_IO{32'h8000_0000}},
    parameter logic [32*NUM_IO-1:0] IO_MASK = {NUM_IO{32'hFFFF_F000}},
    parameter int unsigned          TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dmem_ren,
    input  logic [ADDR_W-1:0]        dmem_raddr,
    output logic [DATA_W-1:0]        dmem_rdata,
    input  logic                     dmem_wen,
    input  logic [ADDR_W-1:0]        dmem_waddr,
    input  logic [DATA_W-1:0]        dmem_wdata,
    input  logic [STRB_W-1:0]        dmem_wstrb,
    output logic                     dmem_stall,
    output logic                     bram_ren,
    input  logic [DATA_W-1:0]        bram_rdata,
    output logic                     bram_wen,
    output logic [NUM_IO-1:0]        io_req_valid,
    input  logic [NUM_IO-1:0]        io_req_ready,
    output logic                     io_req_write,
    output logic [ADDR_W-1:0]        io_req_addr,
    output logic [DATA_W-1:0]        io_req_wdata,
    output logic [STRB_W-1:0]        io_req_wstrb,
    input  logic [NUM_IO-1:0]        io_rsp_valid,
    input  logic [NUM_IO*DATA_W-1:0] io_rsp_rdata,
    output logic                     bus_err,
    output logic [ADDR_W-1:0]        err_addr
);

    localparam int unsigned CH_W  = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    io_req_t             req_q, req_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_IO-1:0]   valid_q, valid_d;
    logic                stall_q, stall_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sel_reg_q, sel_reg_d;
    logic                bus_err_q, bus_err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic [NUM_IO-1:0]   rd_hit, wr_hit;
    logic [CH_W-1:0]     rd_ch, wr_ch;
    logic                rd_miss, wr_miss;
    logic                rd_io, wr_io, rd_bram, wr_bram;
    logic                accept, rd_acc, wr_acc;
    logic                handshake, rsp_hit, timeout_hit;

    svc_rv_dmem_decode #(
        .NUM_IO  (NUM_IO),
        .IO_BASE (IO_BASE),
        .IO_MASK (IO_MASK)
    ) u_rd_decode (
        .addr   (dmem_raddr),
        .hit_c  (rd_hit),
        .ch_c   (rd_ch),
        .miss_c (rd_miss)
    );

    svc_rv_dmem_decode #(
        .NUM_IO  (NUM_IO),
        .IO_BASE (IO_BASE),
        .IO_MASK (IO_MASK)
    ) u_wr_decode (
        .addr   (dmem_waddr),
        .hit_c  (wr_hit),
        .ch_c   (wr_ch),
        .miss_c (wr_miss)
    );

    assign rd_bram = !dmem_raddr[IO_SEL_BIT];
    assign wr_bram = !dmem_waddr[IO_SEL_BIT];
    assign rd_io   = |rd_hit;
    assign wr_io   = |wr_hit;

    assign accept      = (state_q == ST_IDLE) && !stall_q;
    assign rd_acc      = accept && dmem_ren;
    assign wr_acc      = accept && dmem_wen;
    assign handshake   = io_req_ready[ch_q];
    assign rsp_hit     = io_rsp_valid[ch_q];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // BRAM strobes must be combinational so the 1-cycle BRAM latency holds.
    assign bram_ren = rd_acc && rd_bram;
    assign bram_wen = wr_acc && wr_bram;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        ch_d        = ch_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_ch_d   = pend_ch_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        sel_reg_d   = sel_reg_q;
        bus_err_d   = 1'b0;
        err_addr_d  = err_addr_q;
        valid_d     = '0;
        stall_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_acc && rd_bram) begin
                    sel_reg_d = 1'b0;
                end else if (rd_acc && rd_miss) begin
                    sel_reg_d  = 1'b1;
                    rdata_d    = ERR_RDATA;
                    bus_err_d  = 1'b1;
                    err_addr_d = dmem_raddr;
                end
                if (wr_acc && wr_miss) begin
                    bus_err_d  = 1'b1;
                    err_addr_d = dmem_waddr;
                end
                // A simultaneous IO write goes first; the IO read is parked.
                if (wr_acc && wr_io) begin
                    req_d   = '{write: 1'b1, addr: dmem_waddr,
                                wdata: dmem_wdata, wstrb: dmem_wstrb};
                    ch_d    = wr_ch;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                    if (rd_acc && rd_io) begin
                        pend_d      = 1'b1;
                        pend_addr_d = dmem_raddr;
                        pend_ch_d   = rd_ch;
                    end
                end else if (rd_acc && rd_io) begin
                    req_d   = '{write: 1'b0, addr: dmem_raddr,
                                wdata: '0, wstrb: '0};
                    ch_d    = rd_ch;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (handshake || timeout_hit) begin
                    cnt_d = '0;
                    if (!handshake) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = req_q.addr;
                    end
                    if (req_q.write) begin
                        if (pend_q) begin
                            req_d   = '{write: 1'b0, addr: pend_addr_q,
                                        wdata: '0, wstrb: '0};
                            ch_d    = pend_ch_q;
                            pend_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (handshake) begin
                        state_d = ST_RSP;
                    end else begin
                        rdata_d   = ERR_RDATA;
                        sel_reg_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RSP: begin
                if (rsp_hit) begin
                    rdata_d   = io_rsp_rdata[32*32'(ch_q) +: 32];
                    sel_reg_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (timeout_hit) begin
                    bus_err_d  = 1'b1;
                    err_addr_d = req_q.addr;
                    rdata_d    = ERR_RDATA;
                    sel_reg_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_REQ) begin
            valid_d[ch_d] = 1'b1;
        end
        stall_d = (state_d == ST_REQ) || (state_d == ST_RSP);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            ch_q        <= '0;
            valid_q     <= '0;
            stall_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_ch_q   <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            sel_reg_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ch_q        <= ch_d;
            valid_q     <= valid_d;
            stall_q     <= stall_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_ch_q   <= pend_ch_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            sel_reg_q   <= sel_reg_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign dmem_rdata   = sel_reg_q ? rdata_q : bram_rdata;
    assign dmem_stall   = stall_q;
    assign io_req_valid = valid_q;
    assign io_req_write = req_q.write;
    assign io_req_addr  = req_q.addr;
    assign io_req_wdata = req_q.wdata;
    assign io_req_wstrb = req_q.wstrb;
    assign bus_err      = bus_err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_svc_rv_dmem_router.sv
// Directed bench for svc_rv_dmem_router: a vector table of single-access
// cases followed by hand-written multi-cycle sequences.
module tb_svc_rv_dmem_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_ren;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dmem_wen;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_stall;
    logic        bram_ren;
    logic [31:0] bram_rdata;
    logic        bram_wen;
    logic [1:0]  io_req_valid;
    logic [1:0]  io_req_ready;
    logic        io_req_write;
    logic [31:0] io_req_addr;
    logic [31:0] io_req_wdata;
    logic [3:0]  io_req_wstrb;
    logic [1:0]  io_rsp_valid;
    logic [63:0] io_rsp_rdata;
    logic        bus_err;
    logic [31:0] err_addr;

    int checks = 0;
    int failures = 0;

    svc_rv_dmem_router #(
        .NUM_IO  (2),
        .IO_BASE ({32'h8000_1000, 32'h8000_0000}),
        .IO_MASK ({32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_ren     (dmem_ren),
        .dmem_raddr   (dmem_raddr),
        .dmem_rdata   (dmem_rdata),
        .dmem_wen     (dmem_wen),
        .dmem_waddr   (dmem_waddr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_stall   (dmem_stall),
        .bram_ren     (bram_ren),
        .bram_rdata   (bram_rdata),
        .bram_wen     (bram_wen),
        .io_req_valid (io_req_valid),
        .io_req_ready (io_req_ready),
        .io_req_write (io_req_write),
        .io_req_addr  (io_req_addr),
        .io_req_wdata (io_req_wdata),
        .io_req_wstrb (io_req_wstrb),
        .io_rsp_valid (io_rsp_valid),
        .io_rsp_rdata (io_rsp_rdata),
        .bus_err      (bus_err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    // BRAM model: word 0x10 holds 0x1234_5678, other words addr ^ 0x5A5A_0000.
    function automatic logic [31:0] bram_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'h5A5A_0000);
    endfunction

    always @(posedge clk) begin
        if (bram_ren) bram_rdata <= bram_word(dmem_raddr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Complete an outstanding IO access with an always-ready, always-responding peer.
    task automatic drain();
        bit done = 0;
        io_req_ready = 2'b11;
        io_rsp_valid = 2'b11;
        io_rsp_rdata = {32'h0101_0101, 32'h0202_0202};
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (!dmem_stall && io_req_valid == 2'b00) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout actual=stalled expected=idle");
        end
        io_req_ready = 2'b00;
        io_rsp_valid = 2'b00;
    endtask

    typedef struct {
        string       name;
        logic        ren;
        logic [31:0] raddr;
        logic        wen;
        logic [31:0] waddr;
        logic        exp_bren;
        logic        exp_bwen;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_stall;
        logic        exp_err;
        logic [31:0] exp_eaddr;
        logic [1:0]  exp_valid;
        logic        io;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rst          = 1'b1;
        dmem_ren     = 1'b0;
        dmem_raddr   = '0;
        dmem_wen     = 1'b0;
        dmem_waddr   = '0;
        dmem_wdata   = 32'h0BAD_F00D;
        dmem_wstrb   = 4'hF;
        io_req_ready = 2'b00;
        io_rsp_valid = 2'b00;
        io_rsp_rdata = '0;

        //          name         ren  raddr          wen  waddr          bren bwen chk  rdata          stall err  eaddr          valid  io
        vecs[0] = '{"bram_rd",   1'b1, 32'h0000_0010, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0};
        vecs[1] = '{"bram_wr",   1'b0, 32'h0,         1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         2'b00, 1'b0};
        vecs[2] = '{"bram_rd2",  1'b1, 32'h0000_0044, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h5A5A_0044, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0};
        vecs[3] = '{"rd_miss",   1'b1, 32'h9000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h9000_0000, 2'b00, 1'b0};
        vecs[4] = '{"wr_miss",   1'b0, 32'h0,         1'b1, 32'hA000_0004, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'hA000_0004, 2'b00, 1'b0};
        vecs[5] = '{"bram_rw",   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 1'b1, 32'h5A5A_0008, 1'b0, 1'b0, 32'hA000_0004, 2'b00, 1'b0};
        vecs[6] = '{"io_gap",    1'b1, 32'h8000_2000, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h8000_2000, 2'b00, 1'b0};
        vecs[7] = '{"io_rd_ch0", 1'b1, 32'h8000_0004, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_2000, 2'b01, 1'b1};
        vecs[8] = '{"io_wr_ch1", 1'b0, 32'h0,         1'b1, 32'h8000_1008, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_2000, 2'b10, 1'b1};
        vecs[9] = '{"no_access", 1'b0, 32'h0000_0010, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_2000, 2'b00, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(dmem_stall), 32'h0);
        chk("rst_valid", 32'(io_req_valid), 32'h0);
        chk("rst_buserr", 32'(bus_err), 32'h0);
        chk("rst_erraddr", err_addr, 32'h0);
        chk("rst_reqaddr", io_req_addr, 32'h0);
        chk("rst_reqwdata", io_req_wdata, 32'h0);
        rst = 1'b0;

        // Vector table
        foreach (vecs[i]) begin
            @(negedge clk);
            dmem_ren   = vecs[i].ren;
            dmem_raddr = vecs[i].raddr;
            dmem_wen   = vecs[i].wen;
            dmem_waddr = vecs[i].waddr;
            #1;
            chk({vecs[i].name, "_bram_ren"}, 32'(bram_ren), 32'(vecs[i].exp_bren));
            chk({vecs[i].name, "_bram_wen"}, 32'(bram_wen), 32'(vecs[i].exp_bwen));
            @(negedge clk);
            if (vecs[i].chk_rd) chk({vecs[i].name, "_rdata"}, dmem_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_stall"}, 32'(dmem_stall), 32'(vecs[i].exp_stall));
            chk({vecs[i].name, "_bus_err"}, 32'(bus_err), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_err_addr"}, err_addr, vecs[i].exp_eaddr);
            chk({vecs[i].name, "_valid"}, 32'(io_req_valid), 32'(vecs[i].exp_valid));
            dmem_ren = 1'b0;
            dmem_wen = 1'b0;
            if (vecs[i].io) drain();
        end

        // IO read ch1: ready at T+1, response 3 cycles later, stray ch0 response ignored
        @(negedge clk);
        dmem_ren = 1'b1; dmem_raddr = 32'h8000_1010;
        @(negedge clk);                                          // T+1
        dmem_ren = 1'b0;
        chk("rd1_valid", 32'(io_req_valid), 32'h2);
        chk("rd1_stall_t1", 32'(dmem_stall), 32'h1);
        chk("rd1_addr", io_req_addr, 32'h8000_1010);
        chk("rd1_write", 32'(io_req_write), 32'h0);
        io_req_ready = 2'b10;
        @(negedge clk);                                          // T+2
        io_req_ready = 2'b00;
        chk("rd1_valid_drop", 32'(io_req_valid), 32'h0);
        chk("rd1_stall_t2", 32'(dmem_stall), 32'h1);
        io_rsp_valid = 2'b01;
        io_rsp_rdata = {32'h0, 32'hDEAD_BEEF};
        @(negedge clk);                                          // T+3
        chk("rd1_stall_t3", 32'(dmem_stall), 32'h1);
        @(negedge clk);                                          // T+4
        chk("rd1_stall_t4", 32'(dmem_stall), 32'h1);
        io_rsp_valid = 2'b10;
        io_rsp_rdata = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        @(negedge clk);                                          // T+5
        io_rsp_valid = 2'b00;
        chk("rd1_stall_t5", 32'(dmem_stall), 32'h0);
        chk("rd1_rdata", dmem_rdata, 32'hCAFE_F00D);
        chk("rd1_buserr", 32'(bus_err), 32'h0);

        // IO write ch0 with ready held low for 4 cycles
        @(negedge clk);
        dmem_wen = 1'b1; dmem_waddr = 32'h8000_0008;
        dmem_wdata = 32'hA5A5_A5A5; dmem_wstrb = 4'b0011;
        @(negedge clk);                                          // T+1
        dmem_wen = 1'b0; dmem_wdata = 32'hFFFF_0000; dmem_wstrb = 4'b1100;
        for (int k = 1; k <= 5; k++) begin
            chk("wr_valid", 32'(io_req_valid), 32'h1);
            chk("wr_stall", 32'(dmem_stall), 32'h1);
            chk("wr_write", 32'(io_req_write), 32'h1);
            chk("wr_addr", io_req_addr, 32'h8000_0008);
            chk("wr_wdata", io_req_wdata, 32'hA5A5_A5A5);
            chk("wr_wstrb", 32'(io_req_wstrb), 32'h3);
            if (k == 5) io_req_ready = 2'b01;
            @(negedge clk);
        end
        io_req_ready = 2'b00;
        chk("wr_release_stall", 32'(dmem_stall), 32'h0);
        chk("wr_release_valid", 32'(io_req_valid), 32'h0);

        // Timeout on ch0 read, then a BRAM read is accepted again
        @(negedge clk);
        dmem_ren = 1'b1; dmem_raddr = 32'h8000_0020;
        @(negedge clk);                                          // T+1
        dmem_ren = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("to_valid", 32'(io_req_valid), 32'h1);
            chk("to_stall", 32'(dmem_stall), 32'h1);
            @(negedge clk);
        end                                                      // T+9
        chk("to_valid_drop", 32'(io_req_valid), 32'h0);
        chk("to_buserr", 32'(bus_err), 32'h1);
        chk("to_erraddr", err_addr, 32'h8000_0020);
        chk("to_stall_end", 32'(dmem_stall), 32'h0);
        chk("to_rdata", dmem_rdata, 32'h0);
        @(negedge clk);                                          // T+10
        chk("to_buserr_pulse", 32'(bus_err), 32'h0);
        dmem_ren = 1'b1; dmem_raddr = 32'h0000_0010;
        #1;
        chk("to_next_bram_ren", 32'(bram_ren), 32'h1);
        @(negedge clk);
        dmem_ren = 1'b0;
        chk("to_next_rdata", dmem_rdata, 32'h1234_5678);
        chk("to_next_stall", 32'(dmem_stall), 32'h0);

        // Simultaneous IO write ch0 and IO read ch1, reset during read RSP
        @(negedge clk);
        dmem_wen = 1'b1; dmem_waddr = 32'h8000_0030;
        dmem_wdata = 32'h1111_2222; dmem_wstrb = 4'hF;
        dmem_ren = 1'b1; dmem_raddr = 32'h8000_1040;
        @(negedge clk);                                          // T+1
        dmem_wen = 1'b0; dmem_ren = 1'b0;
        chk("dual_wr_valid", 32'(io_req_valid), 32'h1);
        chk("dual_wr_write", 32'(io_req_write), 32'h1);
        chk("dual_wr_addr", io_req_addr, 32'h8000_0030);
        io_req_ready = 2'b01;
        @(negedge clk);                                          // T+2
        chk("dual_rd_valid", 32'(io_req_valid), 32'h2);
        chk("dual_rd_write", 32'(io_req_write), 32'h0);
        chk("dual_rd_addr", io_req_addr, 32'h8000_1040);
        chk("dual_rd_stall", 32'(dmem_stall), 32'h1);
        io_req_ready = 2'b10;
        @(negedge clk);                                          // T+3
        io_req_ready = 2'b00;
        chk("dual_rsp_valid", 32'(io_req_valid), 32'h0);
        chk("dual_rsp_stall", 32'(dmem_stall), 32'h1);
        rst = 1'b1;
        @(negedge clk);                                          // T+4
        rst = 1'b0;
        chk("mid_rst_stall", 32'(dmem_stall), 32'h0);
        chk("mid_rst_valid", 32'(io_req_valid), 32'h0);
        chk("mid_rst_buserr", 32'(bus_err), 32'h0);
        chk("mid_rst_erraddr", err_addr, 32'h0);
        chk("mid_rst_reqaddr", io_req_addr, 32'h0);
        chk("mid_rst_rdata", dmem_rdata, 32'h1234_5678);
        io_rsp_valid = 2'b10;
        io_rsp_rdata = {32'h7777_7777, 32'h0};
        @(negedge clk);
        io_rsp_valid = 2'b00;
        chk("late_rsp_stall", 32'(dmem_stall), 32'h0);
        chk("late_rsp_rdata", dmem_rdata, 32'h1234_5678);
        chk("late_rsp_buserr", 32'(bus_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
